// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;
  localparam int CNT_W_DEF   = 16;

  // Width of the mult/div countdown; never narrower than one bit.
  function automatic int md_cnt_w(input int mul_lat, input int div_lat);
    int m;
    m = (mul_lat > div_lat) ? mul_lat : div_lat;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  localparam int MD_CNT_W = md_cnt_w(MUL_LAT_DEF, DIV_LAT_DEF);

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller; master = pipeline, slave = controller.
interface pipe_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_md_dep;
  logic             idex_mem_read;
  logic [4:0]       idex_rt;
  logic             ex_branch_taken;
  logic             ex_md_start;
  logic             ex_md_div;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             md_busy;
  logic             hilo_we;
  logic             md_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_md_dep, idex_mem_read, idex_rt,
           ex_branch_taken, ex_md_start, ex_md_div,
    input  pc_en, ifid_en, ifid_flush, idex_flush, md_busy, hilo_we, md_err, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_md_dep, idex_mem_read, idex_rt,
           ex_branch_taken, ex_md_start, ex_md_div,
    output pc_en, ifid_en, ifid_flush, idex_flush, md_busy, hilo_we, md_err, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detect between the load in EX and the instruction in ID.
module load_use_detect (
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       load_use
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = idex_mem_read && (idex_rt != 5'd0) &&
                    ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: PC/IF/ID/ID-EX enables and flushes, mult/div sequencing, stall counter.
// state | meaning
// IDLE  | no mult/div in flight, new start accepted
// BUSY  | mult/div counting down its latency
// DONE  | one-cycle HI/LO write, dependents still stalled
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int CW = md_cnt_w(MUL_LAT, DIV_LAT);

  md_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             md_err_q, md_err_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             load_use;
  logic             md_stall;
  logic             hilo_we;
  logic             pc_en, ifid_en, ifid_flush, idex_flush;

  load_use_detect u_lud (
    .idex_mem_read (hz.idex_mem_read),
    .idex_rt       (hz.idex_rt),
    .id_rs         (hz.id_rs),
    .id_rt         (hz.id_rt),
    .id_uses_rt    (hz.id_uses_rt),
    .load_use      (load_use)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      md_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      md_err_q <= md_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hilo_we  = 1'b0;
    md_err_d = md_err_q | (hz.ex_md_start & (state_q != IDLE));
    unique case (state_q)
      IDLE: begin
        if (hz.ex_md_start) begin
          state_d = BUSY;
          cnt_d   = hz.ex_md_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      DONE: begin
        hilo_we = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign md_stall = hz.id_md_dep & ((state_q == BUSY) | (state_q == DONE));

  // A taken branch kills the stalled instruction, so flush wins over stall.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (hz.ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use | md_stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (!pc_en && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hz.pc_en      = pc_en;
  assign hz.ifid_en    = ifid_en;
  assign hz.ifid_flush = ifid_flush;
  assign hz.idex_flush = idex_flush;
  assign hz.md_busy    = (state_q == BUSY);
  assign hz.hilo_we    = hilo_we;
  assign hz.md_err     = md_err_q;
  assign hz.stall_cnt  = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the five-stage MIPS pipeline. Each cycle it decides whether the PC and IF/ID registers advance, and whether IF/ID or the ID/EX control register is flushed to a bubble. It also sequences a multi-cycle multiply/divide unit launched from EX, stalling dependent instructions in ID until the HI/LO write completes. It sits beside the ID stage and drives the enable and flush inputs of PC, IF/ID and ID/EX.

## Interface
- MUL_LAT, 4, multiply latency in cycles (≥1)
- DIV_LAT, 32, divide latency in cycles (≥1)
- CNT_W, 16, width of the stall performance counter
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  5 each  source register fields of the instruction in ID
- id_uses_rt  in  1  instruction in ID reads rt as an operand
- id_md_dep  in  1  instruction in ID reads HI/LO or is a mult/div
- idex_mem_read  in  1  instruction in EX is a load
- idex_rt  in  5  destination register of the load in EX
- ex_branch_taken  in  1  branch or jump in EX resolved taken
- ex_md_start  in  1  valid mult/div in EX (the caller qualifies out bubbles)
- ex_md_div  in  1  with ex_md_start: 1 = divide, 0 = multiply
- pc_en, ifid_en  out  1  write enables for PC and IF/ID
- ifid_flush, idex_flush  out  1  clear IF/ID, or clear the ID/EX control fields (bubble)
- md_busy  out  1  mult/div in flight (state BUSY)
- hilo_we  out  1  one-cycle pulse that writes the HI/LO result
- md_err  out  1  sticky: ex_md_start seen while not IDLE
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0

## Operation
- load_use = idex_mem_read & (idex_rt≠0) & (idex_rt==id_rs | (id_uses_rt & idex_rt==id_rt)).
- md_stall = id_md_dep & (state==BUSY | state==DONE).
- Priority is flush > stall.
- If ex_branch_taken: ifid_flush=1, idex_flush=1, pc_en=1, ifid_en=1. Any stall condition is ignored because the stalled instruction is being killed.
- Else if load_use | md_stall: pc_en=0, ifid_en=0, idex_flush=1.
- Else: pc_en=1, ifid_en=1, both flushes 0.
- All of the above outputs are combinational from inputs and state.
- Mult/div FSM (state md_state_t):
  - IDLE: on ex_md_start, load cnt = (ex_md_div ? DIV_LAT : MUL_LAT) − 1 and go to BUSY.
  - BUSY: if cnt==0 go to DONE, else cnt−−.
  - DONE: hilo_we=1 for this cycle only, then go to IDLE.
- ex_md_start in BUSY or DONE is ignored and sets md_err; it stays set until reset.
- A branch flush does not abort an in-flight mult/div, because that instruction is older than the branch.
- stall_cnt increments when pc_en=0 and holds at 2^CNT_W−1.

## Timing
- Reset (rst low, asynchronous) sets: state=IDLE, cnt=0, md_err=0, stall_cnt=0.
- Output values during reset with no hazard inputs: pc_en=1, ifid_en=1, ifid_flush=0, idex_flush=0, md_busy=0, hilo_we=0.
- Load-use stall lasts exactly one cycle. Once the load moves to MEM, idex_mem_read falls and ID proceeds.
- ex_md_start sampled at edge T:
  - md_busy is high for exactly LAT cycles (T+1 … T+LAT).
  - hilo_we is high in cycle T+LAT+1.
  - IDLE is reached at edge T+LAT+2.
- A dependent instruction in ID stalls through the DONE cycle and advances in the first IDLE cycle.
- ex_md_start in the DONE cycle is ignored and sets md_err. Back-to-back issue is legal only from IDLE.
- Reset asserted mid-BUSY aborts the operation immediately; hilo_we is never pulsed for it.
- Load-use and md_stall in the same cycle produce one stall cycle per cycle of overlap; they are not counted twice.

## Structure
- Package pipe_ctrl_pkg holds:
  - typedef enum md_state_t {IDLE, BUSY, DONE}
  - MD_CNT_W = $clog2(max(MUL_LAT, DIV_LAT))
  - default latency constants
- Sub-module load_use_detect is purely combinational and computes load_use from the five register/flag inputs.
- The top module holds the FSM, the counter, the priority logic and stall_cnt.

## Test plan
- Load to r5 in EX, ID reads rs=5 → one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle pc_en=1. stall_cnt=1.
- Load with idex_rt=0 while ID reads r0 → no stall. Load to rt=7, ID rt=7 with id_uses_rt=0 → no stall.
- ex_branch_taken together with a load_use hazard → ifid_flush=1, idex_flush=1, pc_en=1; stall_cnt unchanged.
- Multiply start at cycle 10, id_md_dep held high → md_busy in cycles 11–14, hilo_we in cycle 15, stall in cycles 11–15, pc_en=1 in cycle 16.
- Divide start → md_busy for exactly 32 cycles. ex_md_start pulsed again in cycle 20 → ignored and md_err=1; after DONE a new start is accepted.
- Reset pulsed mid-divide → md_busy drops immediately, no hilo_we, stall_cnt=0. Force stall for 2^16+5 cycles → stall_cnt holds at 0xFFFF.
